apb_capture_fifo: RTL

- Capture buffer that sits between the on-FPGA data generator and the CPU-side APB bus.
- Accepts an 8-bit sample stream into a DEPTH-entry FIFO while armed.
- Serves samples to the CPU through an APB3 slave with a proper registered PREADY handshake, plus status and control registers.
- Intended to provide the generator-to-APB readout path in the board top as a self-contained, reusable block.

---
 rtl/apb_capture_fifo.sv | 135 +++++++++++++
 1 files changed

// File: rtl/apb_capture_fifo.sv
// Capture FIFO between the sample generator and the CPU's APB3 bus.
// Samples are captured while armed; the CPU pops them through DATA and controls capture through CTRL.
module apb_capture_fifo #(
  parameter int DEPTH = 256,
  parameter int AW    = 16
) (
  input  logic          clk,
  input  logic          rst_h,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          full,
  input  logic          psel,
  input  logic          penable,
  input  logic [AW-1:0] paddr,
  input  logic          pwrite,
  input  logic [31:0]   pwdata,
  output logic [31:0]   prdata,
  output logic          pready,
  output logic          pslverr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          armed_q, armed_d, done_q, done_d, ovf_q, ovf_d;
  logic [31:0]   prdata_q, prdata_d;
  logic          pready_q, pready_d, pslverr_q, pslverr_d;
  logic          empty, access, push, pop, ctrl_wr;
  logic [31:0]   status;
  logic          unused_bits;

  assign unused_bits = ^{pwdata[31:2], paddr[AW-1:4], paddr[1:0]};

  always_comb begin
    full    = (count_q == CW'(DEPTH));
    empty   = (count_q == '0);
    status  = {16'b0, 11'(count_q), 1'b0, ovf_q, done_q, full, empty};
    // The access phase is taken only once; the registered pready blocks re-entry.
    access  = psel & penable & ~pready_q;
    pready_d  = access;
    prdata_d  = '0;
    pslverr_d = 1'b0;
    pop       = 1'b0;
    ctrl_wr   = 1'b0;
    if (access) begin
      unique case (paddr[3:2])
        2'd0: begin
          if (!pwrite && !empty) begin
            prdata_d = {24'b0, mem_q[rptr_q]};
            pop      = 1'b1;
          end else begin
            pslverr_d = 1'b1;
          end
        end
        2'd1: begin
          if (!pwrite) prdata_d = status;
          else         pslverr_d = 1'b1;
        end
        2'd2: begin
          if (pwrite) ctrl_wr = 1'b1;
          else        pslverr_d = 1'b1;
        end
        default: pslverr_d = 1'b1;
      endcase
    end

    push    = armed_q & in_valid & ~full;
    wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + PW'(1) : rptr_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    armed_d = armed_q;
    done_d  = done_q;
    ovf_d   = ovf_q | (in_valid & full);
    // One-shot: the push that fills the buffer ends the capture.
    if (push && !pop && count_q == CW'(DEPTH - 1)) begin
      armed_d = 1'b0;
      done_d  = 1'b1;
    end

    if (ctrl_wr) begin
      if (pwdata[1]) begin
        wptr_d  = '0;
        rptr_d  = '0;
        count_d = '0;
        armed_d = 1'b0;
        done_d  = 1'b0;
        ovf_d   = 1'b0;
      end else if (pwdata[0]) begin
        armed_d = 1'b1;
        done_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_h) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      armed_q   <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      armed_q   <= armed_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= in_data;
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule
